// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: handshake intake, per-word parity, start/data/parity/stop serialiser
module uart_tx_framer #(
  parameter int DATA_W       = 7,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        par_mode,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              p_b,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     baud_cnt, baud_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic              stop_cnt, stop_n;
  logic [DATA_W-1:0] sh_q, sh_n;
  logic              par_en, par_en_n;
  logic              tx_n, p_b_n, busy_n, ready_n, done_n;
  logic              baud_end, last_stop;

  // Outputs are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    baud_end  = (baud_cnt == BAUD_LAST);
    last_stop = (STOP_BITS == 1) || stop_cnt;
    state_n   = state;
    baud_n    = baud_end ? '0 : baud_cnt + 1'b1;
    bit_n     = bit_cnt;
    stop_n    = stop_cnt;
    sh_n      = sh_q;
    par_en_n  = par_en;
    tx_n      = tx;
    p_b_n     = p_b;
    busy_n    = busy;
    ready_n   = din_ready;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (din_valid && din_ready) begin
          state_n  = START;
          sh_n     = din;
          par_en_n = (par_mode == 2'b01) || (par_mode == 2'b10);
          p_b_n    = (par_mode == 2'b01) ? ^din : (par_mode == 2'b10) ? ~^din : 1'b0;
          tx_n     = 1'b0;
          busy_n   = 1'b1;
          ready_n  = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = sh_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = par_en ? PARITY : STOP;
            tx_n    = par_en ? p_b : 1'b1;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_cnt + 1'b1;
            sh_n  = sh_q >> 1;
            tx_n  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (baud_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        done_n = last_stop && (baud_cnt == BAUD_PRE);
        if (baud_end) begin
          if (last_stop) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            ready_n = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      sh_q       <= '0;
      par_en     <= 1'b0;
      tx         <= 1'b1;
      p_b        <= 1'b0;
      busy       <= 1'b0;
      din_ready  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      stop_cnt   <= stop_n;
      sh_q       <= sh_n;
      par_en     <= par_en_n;
      tx         <= tx_n;
      p_b        <= p_b_n;
      busy       <= busy_n;
      din_ready  <= ready_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - bench for uart_tx_framer: one-stop and two-stop instances against a frame-level model
module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] din_i   [2];
  logic [1:0] mode_i  [2];
  logic       valid_i [2];
  logic       rdy_o   [2];
  logic       tx_o    [2];
  logic       pb_o    [2];
  logic       busy_o  [2];
  logic       done_o  [2];

  int checks   = 0;
  int failures = 0;

  uart_tx_framer #(.DATA_W(7), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_i[0]), .par_mode(mode_i[0]), .din_valid(valid_i[0]),
    .din_ready(rdy_o[0]), .tx(tx_o[0]), .p_b(pb_o[0]), .busy(busy_o[0]), .frame_done(done_o[0]));

  uart_tx_framer #(.DATA_W(7), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_i[1]), .par_mode(mode_i[1]), .din_valid(valid_i[1]),
    .din_ready(rdy_o[1]), .tx(tx_o[1]), .p_b(pb_o[1]), .busy(busy_o[1]), .frame_done(done_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame model: a frame is a list of bit values in time order, each lasting CPB cycles.
  logic [15:0] frm [2];
  int          nb  [2];
  int          t   [2];
  bit          act [2];
  logic        mpb [2];
  logic        mpar;

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        act[k] = 1'b0;
        t[k]   = 0;
        mpb[k] = 1'b0;
      end else if (act[k]) begin
        if (t[k] == nb[k] * CPB - 1) act[k] = 1'b0;
        else t[k]++;
      end else if (valid_i[k]) begin
        mpar   = (mode_i[k] == 2'b01) || (mode_i[k] == 2'b10);
        mpb[k] = mpar ? ((^din_i[k]) ^ (mode_i[k] == 2'b10)) : 1'b0;
        frm[k] = '1;
        frm[k][0] = 1'b0;
        for (int i = 0; i < 7; i++) frm[k][1+i] = din_i[k][i];
        if (mpar) frm[k][8] = mpb[k];
        nb[k]  = 8 + (mpar ? 1 : 0) + (k == 0 ? 1 : 2);
        act[k] = 1'b1;
        t[k]   = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic etx, edone;
      etx   = act[k] ? frm[k][t[k] / CPB] : 1'b1;
      edone = act[k] && (t[k] == nb[k] * CPB - 1);
      checks++;
      if (tx_o[k] !== etx || busy_o[k] !== act[k] || rdy_o[k] !== !act[k] ||
          done_o[k] !== edone || (act[k] && pb_o[k] !== mpb[k])) begin
        failures++;
        $display("FAIL cycle_cmp k=%0d at %0t got/want tx=%b/%b busy=%b/%b rdy=%b/%b done=%b/%b pb=%b/%b",
                 k, $time, tx_o[k], etx, busy_o[k], act[k], rdy_o[k], !act[k], done_o[k], edone, pb_o[k], mpb[k]);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_tx(input string nm, input string pat, input int off, input logic [127:0] w);
    int bad;
    bad = -1;
    for (int j = 0; j < pat.len() * CPB; j++)
      if (bad < 0 && w[off+j] !== (pat[j/CPB] == 8'h31)) bad = j;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s tx at cycle %0d got=%b want pattern %s", nm, bad, w[off+bad], pat);
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (act[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL idle_timeout k=%0d got busy want idle", k);
    end
  endtask

  // Offers d1 for one edge (or holds valid with d2 queued), then records n cycles from acceptance.
  task automatic capture(input int k, input logic [6:0] d1, input logic [1:0] m1, input bit hold,
                         input logic [6:0] d2, input logic [1:0] m2, input int n,
                         output logic [127:0] txw, output logic [127:0] fdw,
                         output logic [127:0] rdyw, output logic [127:0] pbw);
    wait_idle(k);
    din_i[k] = d1; mode_i[k] = m1; valid_i[k] = 1'b1;
    txw = '0; fdw = '0; rdyw = '0; pbw = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      txw[j] = tx_o[k]; fdw[j] = done_o[k]; rdyw[j] = rdy_o[k]; pbw[j] = pb_o[k];
      if (hold && j == 0) begin
        din_i[k] = d2; mode_i[k] = m2;
      end else if (!hold && (j == 0 || j == n / 2)) begin
        valid_i[k] = 1'b0; din_i[k] = 7'($urandom); mode_i[k] = 2'($urandom);
      end
    end
    valid_i[k] = 1'b0;
  endtask

  task automatic single(input string nm, input logic [6:0] d, input logic [1:0] m,
                        input string pat, input logic pb);
    logic [127:0] txw, fdw, rdyw, pbw;
    int L;
    L = pat.len() * CPB;
    capture(0, d, m, 1'b0, 7'd0, 2'd0, L + 2, txw, fdw, rdyw, pbw);
    chk_tx({nm, "_tx"}, pat, 0, txw);
    chk({nm, "_done"}, fdw, 128'd1 << (L - 1));
    chk({nm, "_ready"}, rdyw, 128'd3 << L);
    chk({nm, "_pb"}, {127'd0, pbw[0]}, {127'd0, pb});
  endtask

  logic [127:0] txw, fdw, rdyw, pbw;

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din_i[k] = '0; mode_i[k] = '0; valid_i[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx", {127'd0, tx_o[0]}, 128'd1);
    chk("reset_ready", {127'd0, rdy_o[0]}, 128'd1);
    chk("reset_busy", {127'd0, busy_o[0]}, 128'd0);
    chk("reset_done", {127'd0, done_o[0]}, 128'd0);
    chk("reset_pb", {127'd0, pb_o[0]}, 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    single("even",   7'b0000001, 2'b01, "0100000011", 1'b1);
    single("odd_a",  7'b0001100, 2'b10, "0001100011", 1'b1);
    single("odd_b",  7'b0000111, 2'b10, "0111000001", 1'b0);
    single("none",   7'b1011101, 2'b00, "010111011",  1'b0);
    single("rsvd",   7'b1011101, 2'b11, "010111011",  1'b0);

    capture(1, 7'h55, 2'b01, 1'b1, 7'h2A, 2'b01, 89, txw, fdw, rdyw, pbw);
    chk_tx("b2b_f1_tx", "01010101011", 0, txw);
    chk("b2b_gap_tx", {127'd0, txw[44]}, 128'd1);
    chk_tx("b2b_f2_tx", "00101010111", 45, txw);
    chk("b2b_done", fdw, (128'd1 << 43) | (128'd1 << 88));
    chk("b2b_ready", rdyw, 128'd1 << 44);
    chk("b2b_pb", {126'd0, pbw[45], pbw[0]}, 128'b10);

    wait_idle(0);
    din_i[0] = 7'h33; mode_i[0] = 2'b01; valid_i[0] = 1'b1;
    @(negedge clk);
    valid_i[0] = 1'b0;
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", {127'd0, tx_o[0]}, 128'd1);
    chk("midrst_busy", {127'd0, busy_o[0]}, 128'd0);
    chk("midrst_ready", {127'd0, rdy_o[0]}, 128'd1);
    chk("midrst_done", {127'd0, done_o[0]}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    single("post_rst", 7'h5A, 2'b10, "0010110111", 1'b1);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        din_i[k]   = 7'($urandom);
        mode_i[k]  = 2'($urandom);
        valid_i[k] = ($urandom_range(0, 3) == 0);
      end
    end
    valid_i[0] = 1'b0;
    valid_i[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
